register_tree_pq_ctrl: RTL and testbench
========================================

Name: register_tree_pq_ctrl

Overview:
Parametrised successor to the pipelined register-tree priority queue. It adds a selectable max/min ordering, a valid/ready handshake with deterministic busy latency, occupancy reporting and a defined drop policy. The block holds up to QUEUE_SIZE keys in a binary-heap register tree. Root is presented combinationally on o_data. It sits between a scheduler front-end and consumers that pop the best-priority key.

Parameters:
QUEUE_SIZE, 15, node count; must equal 2^LEVELS-1 with LEVELS >= 1 (elaboration error otherwise).
DATA_WIDTH, 16, key width in bits; keys compared unsigned.
MAX_FIRST, 1, 1 = largest key at root; 0 = smallest key at root.
ENQ_ENA, 1, 1 = enqueue permitted; 0 = enqueue requests ignored (queue preloaded via hierarchy, dequeue/replace only).

Ports:
i_CLK  in  1  clock, rising edge.
i_RST  in  1  reset; asynchronous, active-high.
i_valid  in  1  operation request.
o_ready  out  1  block can accept a request this cycle.
i_wrt  in  1  write flag.
i_read  in  1  read flag.
i_data  in  DATA_WIDTH  key for enqueue/replace.
o_data  out  DATA_WIDTH  current root key; 0 when empty.
o_full  out  1  size == QUEUE_SIZE.
o_empty  out  1  size == 0.
o_size  out  $clog2(QUEUE_SIZE+1)  occupancy.

Behaviour:
- Reset (async, any state, including mid-sift): all nodes 0, size 0, FSM IDLE. o_ready=1, o_empty=1, o_full=0, o_data=0, o_size=0. Takes effect immediately; no partial operation survives.
- Accept when i_valid && o_ready. Decode: wrt&!read = ENQ, read&!wrt = DEQ, both = REPL, neither = NOP. NOP is accepted with no state change and o_ready stays 1.
- "Better" means greater when MAX_FIRST=1, less when MAX_FIRST=0. On equal keys, never swap.
- FSM states: IDLE, SIFT_UP, SIFT_DOWN. Each has a level counter 0..LEVELS-2.
- ENQ, accepted and not full, ENQ_ENA=1:
  - Acceptance edge: write node[size] = i_data, size+1, FSM to SIFT_UP if LEVELS>1.
  - Each SIFT_UP cycle: compare one node with its parent, swap if child is better, move up one level.
- DEQ, accepted and not empty:
  - Acceptance edge: node[0] = node[size-1], node[size-1] = 0, size-1, FSM to SIFT_DOWN.
  - Each SIFT_DOWN cycle: compare the current node with its valid children; pick the better child (left on tie); swap if that child is better than the current node; move down one level.
- REPL, not empty: node[0] = i_data, size unchanged, then SIFT_DOWN. REPL when empty behaves exactly as ENQ. REPL is legal with ENQ_ENA=0.
- Fixed latency, no early exit:
  - FSM spends exactly LEVELS-1 cycles in SIFT_UP or SIFT_DOWN, then returns to IDLE.
  - o_ready=0 for those LEVELS-1 cycles after the acceptance edge.
  - o_data/o_full/o_empty/o_size are valid whenever o_ready=1.
  - With LEVELS=1 there is no busy period.
- Drops: the request is consumed, nothing changes, and no busy period follows, for:
  - ENQ when full,
  - DEQ when empty,
  - ENQ when ENQ_ENA=0 (applies even if not full).
- i_valid while o_ready=0: ignored; requester must hold until accepted.
- Empty nodes (index >= size) are held at 0 and never win a comparison.

Optional Feature:
Macro REGISTER_TREE_PQ_STATS_EN.
- Defined:
  - Adds output o_drop_cnt [15:0]: saturating count of dropped requests per the rules above.
  - Adds output o_hwm [$clog2(QUEUE_SIZE+1)-1:0]: maximum size ever reached.
  - Both clear on i_RST.
- Not defined: ports absent, no counters in the netlist, behaviour otherwise identical.

Test Plan:
- QUEUE_SIZE=7, MAX_FIRST=1: enqueue 5,9,2,7 (wait for o_ready each) -> o_data=9, o_size=4; o_ready low exactly 2 cycles after each accept.
- Continue: dequeue x2 -> o_data 7 then 5, o_size=2; dequeue x3 more -> last dequeue dropped, o_empty=1, o_data=0, o_ready stays 1.
- MAX_FIRST=0: enqueue 40,10,30 then replace 20 -> o_data=20, size=3; second replace 50 -> o_data=30.
- Fill 7 keys 1..7, enqueue 8 -> o_full=1, contents unchanged, o_data=7, no busy cycle; with STATS_EN o_drop_cnt=1, o_hwm=7.
- ENQ_ENA=0 with hierarchically preloaded heap {100,80,60}: enqueue 500 -> o_data=100, size=3; replace 70 -> o_data=80.
- Assert i_RST mid-SIFT_DOWN -> same cycle o_empty=1, o_data=0, o_ready=1; next enqueue 3 -> o_data=3.

Source files
------------

// File: rtl/register_tree_pq_ctrl.sv
// register_tree_pq_ctrl
//   Binary-heap priority queue held in a register tree. The root (best key)
//   is presented combinationally on o_data. Each accepted insert, delete or
//   replace is followed by a fixed LEVELS-1 cycle sift during which o_ready
//   is low. Requests that cannot be honoured (enqueue when full or when
//   enqueue is disabled, dequeue when empty) are consumed with no state change
//   and no busy period.
//
//   Optional statistics: define REGISTER_TREE_PQ_STATS_EN to add o_drop_cnt
//   (saturating count of dropped requests) and o_hwm (maximum occupancy seen).
//
// Ports
//   i_CLK      clock, rising edge
//   i_RST      asynchronous active-high reset
//   i_valid    request strobe, accepted when o_ready is high
//   o_ready    idle, able to accept a request this cycle
//   i_wrt      write flag   (wrt only = enqueue, wrt+read = replace root)
//   i_read     read flag    (read only = dequeue root)
//   i_data     key for enqueue / replace
//   o_data     current root key, 0 when empty
//   o_full     occupancy == QUEUE_SIZE
//   o_empty    occupancy == 0
//   o_size     occupancy
//   o_drop_cnt (stats build) dropped request count, saturates at 16'hFFFF
//   o_hwm      (stats build) highest occupancy reached since reset
//
// FSM states
//   state        | meaning
//   ST_IDLE      | waiting for a request, o_ready high
//   ST_SIFT_UP   | new key bubbling from its leaf towards the root
//   ST_SIFT_DOWN | root key sinking towards the leaves

module register_tree_pq_ctrl #(
    parameter int QUEUE_SIZE = 15,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_FIRST  = 1,
    parameter int ENQ_ENA    = 1
) (
    input  logic                             i_CLK,
    input  logic                             i_RST,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic                             i_wrt,
    input  logic                             i_read,
    input  logic [DATA_WIDTH-1:0]            i_data,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic                             o_full,
    output logic                             o_empty,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]  o_size
`ifdef REGISTER_TREE_PQ_STATS_EN
    ,
    output logic [15:0]                      o_drop_cnt,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]  o_hwm
`endif
);

    localparam int LEVELS = $clog2(QUEUE_SIZE + 1);
    // For a legal size (2^LEVELS-1) the occupancy width also indexes every node.
    localparam int SW     = LEVELS;
    localparam int CW     = (LEVELS > 2) ? $clog2(LEVELS) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LEVELS > 1) ? LEVELS - 2 : 0);

    if (QUEUE_SIZE < 1 || QUEUE_SIZE != (1 << LEVELS) - 1) begin : g_bad_size
        $error("register_tree_pq_ctrl: QUEUE_SIZE must be 2^LEVELS-1 with LEVELS >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SIFT_UP,
        ST_SIFT_DOWN
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           lvl_cnt, lvl_nxt;

    logic [DATA_WIDTH-1:0]   node [QUEUE_SIZE];
    logic [SW-1:0]           size_q;
    logic [SW-1:0]           cur;
    logic [SW-1:0]           last_idx;
    logic [SW-1:0]           par_idx;
    logic [SW-1:0]           ch_idx;
    logic [SW:0]             lc, rc;
    logic                    l_ok, r_ok, pick_r, up_swap, dn_swap;

    logic accept, op_enq, op_deq, op_repl, ins_req;
    logic do_ins, do_del, do_rep;

    // Strict comparison: equal keys never count as better, so ties never swap.
    function automatic logic better(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
        return (MAX_FIRST != 0) ? (a > b) : (a < b);
    endfunction

    assign o_data   = node[0];
    assign o_size   = size_q;
    assign o_full   = (size_q == SW'(QUEUE_SIZE));
    assign o_empty  = (size_q == '0);
    assign last_idx = size_q - 1'b1;

    assign accept  = i_valid && (state == ST_IDLE);
    assign op_enq  = i_wrt && !i_read;
    assign op_deq  = i_read && !i_wrt;
    assign op_repl = i_wrt && i_read;
    // Replacing into an empty queue is treated as a plain insert.
    assign ins_req = op_enq || (op_repl && o_empty);
    assign do_ins  = accept && ins_req && !o_full && (ENQ_ENA != 0);
    assign do_del  = accept && op_deq && !o_empty;
    assign do_rep  = accept && op_repl && !o_empty;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state   <= ST_IDLE;
            lvl_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lvl_cnt <= lvl_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lvl_nxt   = lvl_cnt;
        o_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                lvl_nxt = CNT_LOAD;
                if (LEVELS > 1) begin
                    if (do_ins)
                        state_nxt = ST_SIFT_UP;
                    else if (do_del || do_rep)
                        state_nxt = ST_SIFT_DOWN;
                end
            end
            ST_SIFT_UP, ST_SIFT_DOWN: begin
                if (lvl_cnt == '0)
                    state_nxt = ST_IDLE;
                else
                    lvl_nxt = lvl_cnt - 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sift comparators. Sifting always runs the full depth; once the key has
    // settled the remaining steps find no better neighbour and do nothing.
    always_comb begin
        par_idx = (cur == '0) ? '0 : ((cur - 1'b1) >> 1);
        lc      = {cur, 1'b1};
        rc      = {cur, 1'b0} + (SW+1)'(2);
        l_ok    = lc < {1'b0, size_q};
        r_ok    = rc < {1'b0, size_q};
        pick_r  = r_ok && better(node[rc[SW-1:0]], node[lc[SW-1:0]]);
        ch_idx  = pick_r ? rc[SW-1:0] : lc[SW-1:0];
        up_swap = (cur != '0) && better(node[cur], node[par_idx]);
        dn_swap = l_ok && better(node[ch_idx], node[cur]);
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            for (int i = 0; i < QUEUE_SIZE; i++)
                node[i] <= '0;
            size_q <= '0;
            cur    <= '0;
        end else if (do_ins) begin
            node[size_q] <= i_data;
            size_q       <= size_q + 1'b1;
            cur          <= size_q;
        end else if (do_del) begin
            // With one entry both writes hit node 0; the clear wins.
            node[0]        <= node[last_idx];
            node[last_idx] <= '0;
            size_q         <= last_idx;
            cur            <= '0;
        end else if (do_rep) begin
            node[0] <= i_data;
            cur     <= '0;
        end else if (state == ST_SIFT_UP) begin
            if (up_swap) begin
                node[cur]     <= node[par_idx];
                node[par_idx] <= node[cur];
            end
            cur <= par_idx;
        end else if (state == ST_SIFT_DOWN) begin
            if (dn_swap) begin
                node[cur]    <= node[ch_idx];
                node[ch_idx] <= node[cur];
            end
            cur <= ch_idx;
        end
    end

`ifdef REGISTER_TREE_PQ_STATS_EN
    logic          drop;
    logic [15:0]   drop_cnt;
    logic [SW-1:0] hwm;

    assign drop = accept && ((ins_req && (o_full || (ENQ_ENA == 0))) ||
                             (op_deq && o_empty));

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            drop_cnt <= '0;
            hwm      <= '0;
        end else begin
            if (drop && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 1'b1;
            if (do_ins && ((size_q + 1'b1) > hwm))
                hwm <= size_q + 1'b1;
        end
    end

    assign o_drop_cnt = drop_cnt;
    assign o_hwm      = hwm;
`endif

endmodule

// File: tb/tb_register_tree_pq_ctrl.sv
`timescale 1ns/1ps
module tb_register_tree_pq_ctrl;

    localparam int QS = 7;
    localparam int DW = 16;
    localparam int SW = 3;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   [NI];
    logic          vld   [NI];
    logic          wrt   [NI];
    logic          rd    [NI];
    logic [DW-1:0] din   [NI];
    logic          rdy   [NI];
    logic [DW-1:0] dout  [NI];
    logic          full  [NI];
    logic          empty [NI];
    logic [SW-1:0] sz    [NI];
`ifdef REGISTER_TREE_PQ_STATS_EN
    logic [15:0]   drp   [NI];
    logic [SW-1:0] hwm   [NI];
`endif

    int total = 0;
    int bad   = 0;
    int mq[$];

    register_tree_pq_ctrl #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .MAX_FIRST(1), .ENQ_ENA(1)) u_max (
        .i_CLK(clk), .i_RST(rst[0]), .i_valid(vld[0]), .o_ready(rdy[0]),
        .i_wrt(wrt[0]), .i_read(rd[0]), .i_data(din[0]), .o_data(dout[0]),
        .o_full(full[0]), .o_empty(empty[0]), .o_size(sz[0])
`ifdef REGISTER_TREE_PQ_STATS_EN
        , .o_drop_cnt(drp[0]), .o_hwm(hwm[0])
`endif
    );

    register_tree_pq_ctrl #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .MAX_FIRST(0), .ENQ_ENA(1)) u_min (
        .i_CLK(clk), .i_RST(rst[1]), .i_valid(vld[1]), .o_ready(rdy[1]),
        .i_wrt(wrt[1]), .i_read(rd[1]), .i_data(din[1]), .o_data(dout[1]),
        .o_full(full[1]), .o_empty(empty[1]), .o_size(sz[1])
`ifdef REGISTER_TREE_PQ_STATS_EN
        , .o_drop_cnt(drp[1]), .o_hwm(hwm[1])
`endif
    );

    register_tree_pq_ctrl #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .MAX_FIRST(1), .ENQ_ENA(0)) u_noenq (
        .i_CLK(clk), .i_RST(rst[2]), .i_valid(vld[2]), .o_ready(rdy[2]),
        .i_wrt(wrt[2]), .i_read(rd[2]), .i_data(din[2]), .o_data(dout[2]),
        .o_full(full[2]), .o_empty(empty[2]), .o_size(sz[2])
`ifdef REGISTER_TREE_PQ_STATS_EN
        , .o_drop_cnt(drp[2]), .o_hwm(hwm[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One request: wait (bounded) for ready, present for one edge, then
    // count how many post-edge samples see o_ready low.
    task automatic do_op(input int s, input logic w, input logic r,
                         input logic [DW-1:0] d, output int busy);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rdy[s] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_wait", 32'(rdy[s]), 32'd1);
        vld[s] = 1'b1; wrt[s] = w; rd[s] = r; din[s] = d;
        @(posedge clk); #1;
        vld[s] = 1'b0; wrt[s] = 1'b0; rd[s] = 1'b0;
        busy = 0;
        while (!rdy[s] && busy < 50) begin
            @(posedge clk); #1;
            busy++;
        end
    endtask

    task automatic do_reset(input int s);
        @(negedge clk);
        rst[s] = 1'b1;
        vld[s] = 1'b0;
        @(negedge clk);
        rst[s] = 1'b0;
    endtask

    function automatic int best_pos(input bit maxf);
        int p;
        p = -1;
        for (int i = 0; i < mq.size(); i++)
            if (p < 0 || (maxf ? (mq[i] > mq[p]) : (mq[i] < mq[p])))
                p = i;
        return p;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int pick;
        int bp;
        int exp_busy;
        int drops;
        int hw;
        logic [DW-1:0] d;
        logic w, r;
        bit maxf;

        for (int s = 0; s < NI; s++) begin
            rst[s] = 1'b1; vld[s] = 1'b0; wrt[s] = 1'b0; rd[s] = 1'b0; din[s] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(rdy[0]), 1);
        chk("rst_empty", 32'(empty[0]), 1);
        chk("rst_full", 32'(full[0]), 0);
        chk("rst_data", 32'(dout[0]), 0);
        chk("rst_size", 32'(sz[0]), 0);
        for (int s = 0; s < NI; s++) rst[s] = 1'b0;

        // max-first: enqueue 5,9,2,7
        do_op(0, 1, 0, 16'd5, busy); chk("enq5_busy", busy, 2);
        do_op(0, 1, 0, 16'd9, busy); chk("enq9_busy", busy, 2);
        do_op(0, 1, 0, 16'd2, busy); chk("enq2_busy", busy, 2);
        do_op(0, 1, 0, 16'd7, busy); chk("enq7_busy", busy, 2);
        chk("enq4_data", 32'(dout[0]), 9);
        chk("enq4_size", 32'(sz[0]), 4);
        do_op(0, 0, 1, 16'd0, busy); chk("deq1_data", 32'(dout[0]), 7);
        do_op(0, 0, 1, 16'd0, busy); chk("deq2_data", 32'(dout[0]), 5);
        chk("deq2_size", 32'(sz[0]), 2);
        do_op(0, 0, 1, 16'd0, busy); chk("deq3_data", 32'(dout[0]), 2);
        do_op(0, 0, 1, 16'd0, busy); chk("deq4_busy", busy, 2);
        do_op(0, 0, 1, 16'd0, busy); chk("deq_drop_busy", busy, 0);
        chk("deq_drop_empty", 32'(empty[0]), 1);
        chk("deq_drop_data", 32'(dout[0]), 0);
        chk("deq_drop_ready", 32'(rdy[0]), 1);

        // fill then overflow
        do_reset(0);
        for (int k = 1; k <= 7; k++) begin
            do_op(0, 1, 0, 16'(k), busy);
            chk("fill_busy", busy, 2);
        end
        do_op(0, 1, 0, 16'd8, busy);
        chk("ovf_busy", busy, 0);
        chk("ovf_full", 32'(full[0]), 1);
        chk("ovf_data", 32'(dout[0]), 7);
        chk("ovf_size", 32'(sz[0]), 7);
`ifdef REGISTER_TREE_PQ_STATS_EN
        chk("ovf_drops", 32'(drp[0]), 1);
        chk("ovf_hwm", 32'(hwm[0]), 7);
`endif

        // reset in the middle of a sift-down
        @(negedge clk);
        vld[0] = 1'b1; rd[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0; rd[0] = 1'b0;
        chk("mid_busy", 32'(rdy[0]), 0);
        rst[0] = 1'b1;
        #1;
        chk("mid_rst_empty", 32'(empty[0]), 1);
        chk("mid_rst_data", 32'(dout[0]), 0);
        chk("mid_rst_ready", 32'(rdy[0]), 1);
        chk("mid_rst_size", 32'(sz[0]), 0);
`ifdef REGISTER_TREE_PQ_STATS_EN
        chk("mid_rst_drops", 32'(drp[0]), 0);
        chk("mid_rst_hwm", 32'(hwm[0]), 0);
`endif
        @(negedge clk);
        rst[0] = 1'b0;
        do_op(0, 1, 0, 16'd3, busy);
        chk("post_rst_data", 32'(dout[0]), 3);
        chk("post_rst_size", 32'(sz[0]), 1);

        // min-first with replace
        do_op(1, 1, 0, 16'd40, busy);
        do_op(1, 1, 0, 16'd10, busy);
        do_op(1, 1, 0, 16'd30, busy);
        chk("min_enq_data", 32'(dout[1]), 10);
        do_op(1, 1, 1, 16'd20, busy);
        chk("min_repl1_busy", busy, 2);
        chk("min_repl1_data", 32'(dout[1]), 20);
        chk("min_repl1_size", 32'(sz[1]), 3);
        do_op(1, 1, 1, 16'd50, busy);
        chk("min_repl2_data", 32'(dout[1]), 30);

        // enqueue disabled, heap preloaded through hierarchy
        @(negedge clk);
        u_noenq.node[0] = 16'd100;
        u_noenq.node[1] = 16'd80;
        u_noenq.node[2] = 16'd60;
        u_noenq.size_q  = 3'd3;
        #1;
        chk("pre_data", 32'(dout[2]), 100);
        do_op(2, 1, 0, 16'd500, busy);
        chk("noenq_busy", busy, 0);
        chk("noenq_data", 32'(dout[2]), 100);
        chk("noenq_size", 32'(sz[2]), 3);
        do_op(2, 1, 1, 16'd70, busy);
        chk("noenq_repl_busy", busy, 2);
        chk("noenq_repl_data", 32'(dout[2]), 80);
        do_op(2, 0, 1, 16'd0, busy);
        chk("noenq_deq_data", 32'(dout[2]), 70);
        chk("noenq_deq_size", 32'(sz[2]), 2);
`ifdef REGISTER_TREE_PQ_STATS_EN
        chk("noenq_drops", 32'(drp[2]), 1);
`endif

        // random traffic against a multiset model
        for (int s = 0; s < 2; s++) begin
            maxf = (s == 0);
            do_reset(s);
            mq.delete();
            drops = 0;
            hw = 0;
            for (int n = 0; n < 150; n++) begin
                pick = $urandom_range(0, 9);
                d = 16'($urandom_range(0, 31));
                exp_busy = 0;
                bp = best_pos(maxf);
                if (pick <= 3) begin
                    w = 1; r = 0;
                    if (mq.size() < QS) begin mq.push_back(int'(d)); exp_busy = 2; end
                    else drops++;
                end else if (pick <= 6) begin
                    w = 0; r = 1;
                    if (mq.size() > 0) begin mq.delete(bp); exp_busy = 2; end
                    else drops++;
                end else if (pick <= 8) begin
                    w = 1; r = 1;
                    if (mq.size() == 0) mq.push_back(int'(d));
                    else mq[bp] = int'(d);
                    exp_busy = 2;
                end else begin
                    w = 0; r = 0;
                end
                if (mq.size() > hw) hw = mq.size();
                do_op(s, w, r, d, busy);
                bp = best_pos(maxf);
                chk("rnd_busy", busy, exp_busy);
                chk("rnd_data", 32'(dout[s]), (bp < 0) ? 0 : mq[bp]);
                chk("rnd_size", 32'(sz[s]), mq.size());
                chk("rnd_full", 32'(full[s]), (mq.size() == QS) ? 1 : 0);
                chk("rnd_empty", 32'(empty[s]), (mq.size() == 0) ? 1 : 0);
            end
`ifdef REGISTER_TREE_PQ_STATS_EN
            chk("rnd_drops", 32'(drp[s]), drops);
            chk("rnd_hwm", 32'(hwm[s]), hw);
`else
            if (drops < 0 || hw < 0) chk("rnd_model", 0, 1);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
